pipeline_latch_bank: RTL



---
 rtl/pipeline_latch_bank_if.sv | 108 ++++++++++
 rtl/pipeline_latch_bank.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_latch_bank_if.sv
// Purpose: bundles every signal between the pipeline latch bank and its
//          neighbours (fetch, decode, execute, memory stages and the hazard unit).
// Ports:   slave = latch bank side (stage inputs/commands in, latch fields out);
//          master = surrounding datapath/hazard unit side (directions mirrored).
interface pipeline_latch_bank_if #(
    parameter int WORD_W = 32
);
    // fetch/memory status and hazard-unit commands
    logic              ihit;
    logic              dhit;
    logic              ifid_en;
    logic              ifid_flush;
    logic              idex_en;
    logic              idex_flush;
    logic              exmem_flush;

    // stage inputs
    logic [WORD_W-1:0] if_instr;
    logic [WORD_W-1:0] if_npc;
    logic [4:0]        id_wsel;
    logic              id_regWEN;
    logic              id_dREN;
    logic              id_dWEN;
    logic [2:0]        id_PCSrc;
    logic [2:0]        id_MemToReg;
    logic [WORD_W-1:0] id_rdat1;
    logic [WORD_W-1:0] id_rdat2;
    logic [WORD_W-1:0] id_imm;
    logic [WORD_W-1:0] ex_result;
    logic              ex_ZeroFlag;
    logic [WORD_W-1:0] ex_btarget;
    logic [WORD_W-1:0] mem_dload;

    // IF/ID
    logic [WORD_W-1:0] ifid_instr;
    logic [WORD_W-1:0] ifid_npc;
    logic              ifid_valid;
    logic [4:0]        ifid_rs;
    logic [4:0]        ifid_rt;

    // ID/EX
    logic [4:0]        idex_wsel;
    logic              idex_regWEN;
    logic              idex_dREN;
    logic              idex_dWEN;
    logic [2:0]        idex_PCSrc;
    logic [2:0]        idex_MemToReg;
    logic [WORD_W-1:0] idex_rdat1;
    logic [WORD_W-1:0] idex_rdat2;
    logic [WORD_W-1:0] idex_imm;
    logic [WORD_W-1:0] idex_npc;
    logic              idex_valid;

    // EX/MEM
    logic [4:0]        exmem_wsel;
    logic              exmem_regWEN;
    logic              exmem_dREN;
    logic              exmem_dWEN;
    logic [2:0]        exmem_PCSrc;
    logic [2:0]        exmem_MemToReg;
    logic [WORD_W-1:0] exmem_result;
    logic              exmem_ZeroFlag;
    logic [WORD_W-1:0] exmem_btarget;
    logic [WORD_W-1:0] exmem_wdat;
    logic [WORD_W-1:0] exmem_npc;
    logic              exmem_valid;

    // MEM/WB
    logic [4:0]        memwb_wsel;
    logic              memwb_regWEN;
    logic [2:0]        memwb_MemToReg;
    logic [WORD_W-1:0] memwb_result;
    logic [WORD_W-1:0] memwb_dload;
    logic [WORD_W-1:0] memwb_npc;
    logic              memwb_valid;

    modport slave (
        input  ihit, dhit, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush,
        input  if_instr, if_npc,
        input  id_wsel, id_regWEN, id_dREN, id_dWEN, id_PCSrc, id_MemToReg,
        input  id_rdat1, id_rdat2, id_imm,
        input  ex_result, ex_ZeroFlag, ex_btarget, mem_dload,
        output ifid_instr, ifid_npc, ifid_valid, ifid_rs, ifid_rt,
        output idex_wsel, idex_regWEN, idex_dREN, idex_dWEN, idex_PCSrc, idex_MemToReg,
        output idex_rdat1, idex_rdat2, idex_imm, idex_npc, idex_valid,
        output exmem_wsel, exmem_regWEN, exmem_dREN, exmem_dWEN, exmem_PCSrc,
        output exmem_MemToReg, exmem_result, exmem_ZeroFlag, exmem_btarget,
        output exmem_wdat, exmem_npc, exmem_valid,
        output memwb_wsel, memwb_regWEN, memwb_MemToReg, memwb_result,
        output memwb_dload, memwb_npc, memwb_valid
    );

    modport master (
        output ihit, dhit, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush,
        output if_instr, if_npc,
        output id_wsel, id_regWEN, id_dREN, id_dWEN, id_PCSrc, id_MemToReg,
        output id_rdat1, id_rdat2, id_imm,
        output ex_result, ex_ZeroFlag, ex_btarget, mem_dload,
        input  ifid_instr, ifid_npc, ifid_valid, ifid_rs, ifid_rt,
        input  idex_wsel, idex_regWEN, idex_dREN, idex_dWEN, idex_PCSrc, idex_MemToReg,
        input  idex_rdat1, idex_rdat2, idex_imm, idex_npc, idex_valid,
        input  exmem_wsel, exmem_regWEN, exmem_dREN, exmem_dWEN, exmem_PCSrc,
        input  exmem_MemToReg, exmem_result, exmem_ZeroFlag, exmem_btarget,
        input  exmem_wdat, exmem_npc, exmem_valid,
        input  memwb_wsel, memwb_regWEN, memwb_MemToReg, memwb_result,
        input  memwb_dload, memwb_npc, memwb_valid
    );
endinterface

// File: rtl/pipeline_latch_bank.sv
// Purpose:      IF/ID, ID/EX, EX/MEM, MEM/WB registers of the 5-stage pipe, applying hazard enable/flush.
// Latency:      one edge per stage; every output registered (ifid_rs/rt are slices of ifid_instr).
// Backpressure: an outstanding data access (EX/MEM dREN|dWEN without dhit) freezes all four latches.
// Ports:        CLK, nRST (synchronous, active-low); bus = stage inputs, hazard commands, latch fields.
module pipeline_latch_bank #(
    parameter int WORD_W = 32
) (
    input  logic                 CLK,
    input  logic                 nRST,
    pipeline_latch_bank_if.slave bus
);

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] npc;
        logic              valid;
    } ifid_t;

    typedef struct packed {
        logic [4:0]        wsel;
        logic              regWEN;
        logic              dREN;
        logic              dWEN;
        logic [2:0]        PCSrc;
        logic [2:0]        MemToReg;
        logic [WORD_W-1:0] rdat1;
        logic [WORD_W-1:0] rdat2;
        logic [WORD_W-1:0] imm;
        logic [WORD_W-1:0] npc;
        logic              valid;
    } idex_t;

    typedef struct packed {
        logic [4:0]        wsel;
        logic              regWEN;
        logic              dREN;
        logic              dWEN;
        logic [2:0]        PCSrc;
        logic [2:0]        MemToReg;
        logic [WORD_W-1:0] result;
        logic              ZeroFlag;
        logic [WORD_W-1:0] btarget;
        logic [WORD_W-1:0] wdat;
        logic [WORD_W-1:0] npc;
        logic              valid;
    } exmem_t;

    typedef struct packed {
        logic [4:0]        wsel;
        logic              regWEN;
        logic [2:0]        MemToReg;
        logic [WORD_W-1:0] result;
        logic [WORD_W-1:0] dload;
        logic [WORD_W-1:0] npc;
        logic              valid;
    } memwb_t;

    ifid_t  ifid_q,  ifid_d;
    idex_t  idex_q,  idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;
    logic   freeze;

    // A data access in MEM that has not completed stalls every stage together,
    // so relative spacing between instructions is preserved across the stall.
    assign freeze = (exmem_q.dREN | exmem_q.dWEN) & ~bus.dhit;

    // IF/ID: flush > enable; an enabled latch with no fetched instruction
    // becomes a bubble because its previous contents moved on to ID/EX.
    always_comb begin
        ifid_d = ifid_q;
        if (bus.ifid_flush) begin
            ifid_d = '0;
        end else if (bus.ifid_en) begin
            if (bus.ihit) begin
                ifid_d.instr = bus.if_instr;
                ifid_d.npc   = bus.if_npc;
                ifid_d.valid = 1'b1;
            end else begin
                ifid_d = '0;
            end
        end
    end

    // ID/EX: flush > enable; disabled holds.
    always_comb begin
        idex_d = idex_q;
        if (bus.idex_flush) begin
            idex_d = '0;
        end else if (bus.idex_en) begin
            idex_d.wsel     = bus.id_wsel;
            idex_d.regWEN   = bus.id_regWEN;
            idex_d.dREN     = bus.id_dREN;
            idex_d.dWEN     = bus.id_dWEN;
            idex_d.PCSrc    = bus.id_PCSrc;
            idex_d.MemToReg = bus.id_MemToReg;
            idex_d.rdat1    = bus.id_rdat1;
            idex_d.rdat2    = bus.id_rdat2;
            idex_d.imm      = bus.id_imm;
            idex_d.npc      = ifid_q.npc;
            idex_d.valid    = ifid_q.valid;
        end
    end

    // EX/MEM: loads every unfrozen edge unless flushed; store data is rdat2.
    always_comb begin
        exmem_d = '0;
        if (!bus.exmem_flush) begin
            exmem_d.wsel     = idex_q.wsel;
            exmem_d.regWEN   = idex_q.regWEN;
            exmem_d.dREN     = idex_q.dREN;
            exmem_d.dWEN     = idex_q.dWEN;
            exmem_d.PCSrc    = idex_q.PCSrc;
            exmem_d.MemToReg = idex_q.MemToReg;
            exmem_d.result   = bus.ex_result;
            exmem_d.ZeroFlag = bus.ex_ZeroFlag;
            exmem_d.btarget  = bus.ex_btarget;
            exmem_d.wdat     = idex_q.rdat2;
            exmem_d.npc      = idex_q.npc;
            exmem_d.valid    = idex_q.valid;
        end
    end

    // MEM/WB: never flushed, loads every unfrozen edge.
    always_comb begin
        memwb_d          = '0;
        memwb_d.wsel     = exmem_q.wsel;
        memwb_d.regWEN   = exmem_q.regWEN;
        memwb_d.MemToReg = exmem_q.MemToReg;
        memwb_d.result   = exmem_q.result;
        memwb_d.dload    = bus.mem_dload;
        memwb_d.npc      = exmem_q.npc;
        memwb_d.valid    = exmem_q.valid;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ifid_q  <= '0;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else if (!freeze) begin
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign bus.ifid_instr     = ifid_q.instr;
    assign bus.ifid_npc       = ifid_q.npc;
    assign bus.ifid_valid     = ifid_q.valid;
    assign bus.ifid_rs        = ifid_q.instr[25:21];
    assign bus.ifid_rt        = ifid_q.instr[20:16];

    assign bus.idex_wsel      = idex_q.wsel;
    assign bus.idex_regWEN    = idex_q.regWEN;
    assign bus.idex_dREN      = idex_q.dREN;
    assign bus.idex_dWEN      = idex_q.dWEN;
    assign bus.idex_PCSrc     = idex_q.PCSrc;
    assign bus.idex_MemToReg  = idex_q.MemToReg;
    assign bus.idex_rdat1     = idex_q.rdat1;
    assign bus.idex_rdat2     = idex_q.rdat2;
    assign bus.idex_imm       = idex_q.imm;
    assign bus.idex_npc       = idex_q.npc;
    assign bus.idex_valid     = idex_q.valid;

    assign bus.exmem_wsel     = exmem_q.wsel;
    assign bus.exmem_regWEN   = exmem_q.regWEN;
    assign bus.exmem_dREN     = exmem_q.dREN;
    assign bus.exmem_dWEN     = exmem_q.dWEN;
    assign bus.exmem_PCSrc    = exmem_q.PCSrc;
    assign bus.exmem_MemToReg = exmem_q.MemToReg;
    assign bus.exmem_result   = exmem_q.result;
    assign bus.exmem_ZeroFlag = exmem_q.ZeroFlag;
    assign bus.exmem_btarget  = exmem_q.btarget;
    assign bus.exmem_wdat     = exmem_q.wdat;
    assign bus.exmem_npc      = exmem_q.npc;
    assign bus.exmem_valid    = exmem_q.valid;

    assign bus.memwb_wsel     = memwb_q.wsel;
    assign bus.memwb_regWEN   = memwb_q.regWEN;
    assign bus.memwb_MemToReg = memwb_q.MemToReg;
    assign bus.memwb_result   = memwb_q.result;
    assign bus.memwb_dload    = memwb_q.dload;
    assign bus.memwb_npc      = memwb_q.npc;
    assign bus.memwb_valid    = memwb_q.valid;

endmodule
